// File: rtl/l1_mem_responder.sv
// Memory responder behind the L1D miss/writeback port: single loads, byte-strobed
// stores and critical-word-first line refills after a fixed access latency.
module l1_mem_responder #(
  parameter int DEPTH_WORDS = 65536,
  parameter int LINE_WORDS  = 8,
  parameter int LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        l1_mem_valid,
  input  logic        l1_mem_store,
  input  logic        l1_mem_burst,
  input  logic [31:0] l1_mem_addr,
  input  logic [31:0] l1_mem_wdata,
  input  logic [3:0]  l1_mem_wstrb,
  output logic        mem_l1_ready,
  output logic        mem_l1_valid,
  output logic [31:0] mem_l1_rdata,
  output logic        mem_l1_last
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = $clog2(LINE_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, COMMIT} state_t;

  typedef struct packed {
    logic          store;
    logic          burst;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } req_t;

  state_t        state, state_nxt;
  req_t          req;
  logic [CW-1:0] lat_cnt;
  logic [LW-1:0] beat_k;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          accept, beat_last;
  logic [AW-1:0] beat_idx;
  logic          unused_addr_bits;

  // Aliasing: only the word-index bits of the address are meaningful.
  assign unused_addr_bits = ^{l1_mem_addr[31:AW+2], l1_mem_addr[1:0]};

  assign accept    = l1_mem_valid && mem_l1_ready;
  // Critical-word-first: offset wraps inside the line, line base held constant.
  assign beat_idx  = {req.idx[AW-1:LW], req.idx[LW-1:0] + beat_k};
  assign beat_last = !req.burst || (beat_k == LW'(LINE_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = req.store ? COMMIT : BEAT;
      BEAT:    if (beat_last) state_nxt = IDLE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_l1_ready = 1'b0;
    mem_l1_valid = 1'b0;
    mem_l1_last  = 1'b0;
    mem_l1_rdata = '0;
    case (state)
      IDLE: mem_l1_ready = rst_n;
      BEAT: begin
        mem_l1_valid = 1'b1;
        mem_l1_last  = beat_last;
        mem_l1_rdata = mem[beat_idx];
      end
      COMMIT: begin
        mem_l1_valid = 1'b1;
        mem_l1_last  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req     <= '0;
      lat_cnt <= '0;
      beat_k  <= '0;
    end else begin
      if (accept) begin
        req.store <= l1_mem_store;
        req.burst <= l1_mem_burst && !l1_mem_store;
        req.idx   <= l1_mem_addr[AW+1:2];
        req.wdata <= l1_mem_wdata;
        req.wstrb <= l1_mem_wstrb;
        lat_cnt   <= CW'(LATENCY - 1);
        beat_k    <= '0;
      end
      if (state == WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      if (state == BEAT) beat_k <= beat_k + 1'b1;
    end
  end

  // Storage is deliberately not reset; a reset before COMMIT drops the store.
  always_ff @(posedge clk) begin
    if (state == COMMIT) begin
      for (int b = 0; b < 4; b++)
        if (req.wstrb[b]) mem[req.idx][8*b +: 8] <= req.wdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_l1_mem_responder.sv
// Bench for l1_mem_responder: LATENCY=4 and LATENCY=1 instances against a word-map
// reference with arithmetic critical-word-first ordering.
module tb_l1_mem_responder;
  localparam int LINE = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        vin = '0;
  logic              store = 1'b0, burst = 1'b0;
  logic [31:0]       addr = '0, wdata = '0;
  logic [3:0]        wstrb = '0;
  logic [1:0]        rdy, vo, lo;
  logic [1:0][31:0]  rd;

  int n_cmp = 0, n_err = 0;
  int sel = 0;
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  l1_mem_responder #(.DEPTH_WORDS(65536), .LINE_WORDS(LINE), .LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .l1_mem_valid(vin[0]), .l1_mem_store(store),
    .l1_mem_burst(burst), .l1_mem_addr(addr), .l1_mem_wdata(wdata), .l1_mem_wstrb(wstrb),
    .mem_l1_ready(rdy[0]), .mem_l1_valid(vo[0]), .mem_l1_rdata(rd[0]), .mem_l1_last(lo[0]));

  l1_mem_responder #(.DEPTH_WORDS(65536), .LINE_WORDS(LINE), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .l1_mem_valid(vin[1]), .l1_mem_store(store),
    .l1_mem_burst(burst), .l1_mem_addr(addr), .l1_mem_wdata(wdata), .l1_mem_wstrb(wstrb),
    .mem_l1_ready(rdy[1]), .mem_l1_valid(vo[1]), .mem_l1_rdata(rd[1]), .mem_l1_last(lo[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int key(input int s, input logic [31:0] a);
    return s * 65536 + int'(a[17:2]);
  endfunction

  function automatic logic [31:0] mrd(input int k);
    return mdl.exists(k) ? mdl[k] : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full transaction on instance `sel`, checking every cycle until ready returns.
  task automatic txn(input bit st, input bit bu, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] ws);
    int lat, beats, base, start, n;
    logic [31:0] nw;
    lat   = (sel == 1) ? 1 : 4;
    beats = (bu && !st) ? LINE : 1;
    base  = key(sel, {a[31:5], 5'b0});
    start = int'(a[4:2]);
    store = st; burst = bu; addr = a; wdata = wd; wstrb = ws;
    vin[sel] = 1'b1;
    n = 0;
    while (!rdy[sel] && n < 50) begin tick(); n++; end
    if (n == 50) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    vin[sel] = 1'b0;
    addr = $urandom; wdata = $urandom; store = $urandom; burst = $urandom;
    for (int c = 0; c < lat; c++) begin
      chk("wait_valid", {31'd0, vo[sel]}, 32'd0);
      chk("wait_ready", {31'd0, rdy[sel]}, 32'd0);
      tick();
    end
    if (st) begin
      chk("ack_valid", {31'd0, vo[sel]}, 32'd1);
      chk("ack_last", {31'd0, lo[sel]}, 32'd1);
      chk("ack_rdata", rd[sel], 32'd0);
      nw = mrd(key(sel, a));
      for (int b = 0; b < 4; b++) if (ws[b]) nw[8*b +: 8] = wd[8*b +: 8];
      mdl[key(sel, a)] = nw;
      tick();
    end else begin
      for (int k = 0; k < beats; k++) begin
        chk("beat_valid", {31'd0, vo[sel]}, 32'd1);
        chk("beat_ready", {31'd0, rdy[sel]}, 32'd0);
        chk("beat_last", {31'd0, lo[sel]}, {31'd0, k == beats - 1});
        chk("beat_rdata", rd[sel],
            bu ? mrd(base + (start + k) % LINE) : mrd(key(sel, a)));
        tick();
      end
    end
    chk("end_ready", {31'd0, rdy[sel]}, 32'd1);
    chk("end_valid", {31'd0, vo[sel]}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int op, w;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", {31'd0, rdy[s]}, 32'd0);
      chk("rst_valid", {31'd0, vo[s]}, 32'd0);
      chk("rst_last", {31'd0, lo[s]}, 32'd0);
      chk("rst_rdata", rd[s], 32'd0);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_ready0", {31'd0, rdy[0]}, 32'd1);
    chk("rel_ready1", {31'd0, rdy[1]}, 32'd1);
    tick();

    // Fill lines 0..3 of both instances; line 0 of the slow one holds i at word i.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 32; i++)
        txn(1'b1, 1'b0, 32'(i * 4), (s == 0 && i < 8) ? 32'(i) : $urandom, 4'hF);
    end

    sel = 0;
    txn(1'b0, 1'b1, 32'h0000_0014, 32'h0, 4'h0);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'hDEADBEEF, 4'hF);
    txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    chk("raw_deadbeef", mrd(key(0, 32'h40)), 32'hDEADBEEF);
    txn(1'b1, 1'b0, 32'h0000_0080, 32'h11223344, 4'hF);
    txn(1'b1, 1'b0, 32'h0000_0080, 32'hAABBCCDD, 4'h5);
    txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 4'h0);

    // Valid held high across two loads: second accepted only after the first beat.
    store = 1'b0; burst = 1'b0; addr = 32'h40; vin[0] = 1'b1;
    chk("b2b_rdy0", {31'd0, rdy[0]}, 32'd1);
    tick();
    addr = 32'h80;
    for (int c = 0; c < 4; c++) begin
      chk("b2b_wait1_rdy", {31'd0, rdy[0]}, 32'd0);
      chk("b2b_wait1_vld", {31'd0, vo[0]}, 32'd0);
      tick();
    end
    chk("b2b_beat1", rd[0], 32'hDEADBEEF);
    chk("b2b_beat1_rdy", {31'd0, rdy[0]}, 32'd0);
    tick();
    chk("b2b_idle_rdy", {31'd0, rdy[0]}, 32'd1);
    chk("b2b_idle_vld", {31'd0, vo[0]}, 32'd0);
    tick();
    vin[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("b2b_wait2_rdy", {31'd0, rdy[0]}, 32'd0);
      chk("b2b_wait2_vld", {31'd0, vo[0]}, 32'd0);
      tick();
    end
    chk("b2b_beat2", rd[0], 32'h11BB33DD);
    chk("b2b_beat2_last", {31'd0, lo[0]}, 32'd1);
    tick();
    chk("b2b_end_rdy", {31'd0, rdy[0]}, 32'd1);

    // Reset during WAIT of a store drops it.
    txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    store = 1'b1; burst = 1'b0; addr = 32'h100; wdata = 32'h12345678; wstrb = 4'hF;
    vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    tick();
    rst_n = 1'b0; #1;
    chk("mid_rst_rdy", {31'd0, rdy[0]}, 32'd0);
    chk("mid_rst_vld", {31'd0, vo[0]}, 32'd0);
    chk("mid_rst_last", {31'd0, lo[0]}, 32'd0);
    chk("mid_rst_rdata", rd[0], 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("mid_rel_rdy", {31'd0, rdy[0]}, 32'd1);
    tick();
    txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);

    // One-cycle latency, aliased address, store with burst set.
    sel = 1;
    txn(1'b1, 1'b0, 32'h0004_0000, 32'hCAFEF00D, 4'hF);
    txn(1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0);
    chk("alias_word0", mrd(key(1, 32'h0)), 32'hCAFEF00D);
    txn(1'b1, 1'b1, 32'h0000_0008, 32'h5A5A5A5A, 4'hF);
    txn(1'b0, 1'b1, 32'h0000_001C, 32'h0, 4'h0);

    for (int it = 0; it < 60; it++) begin
      sel = int'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 3));
      w   = int'($urandom_range(0, 31));
      a   = ($urandom & 32'hFFFC_0000) | 32'(w * 4) | 32'($urandom_range(0, 3));
      case (op)
        0: txn(1'b1, 1'b0, a, $urandom, 4'($urandom));
        1: txn(1'b0, 1'b0, a, $urandom, 4'($urandom));
        2: txn(1'b0, 1'b1, a, $urandom, 4'($urandom));
        default: txn(1'b1, 1'b1, a, $urandom, 4'($urandom));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/l1_mem_responder.md
Name: l1_mem_responder

Overview:
- Main-memory responder sitting on the far end of the L1D miss/writeback interface.
- Accepts single-word loads, single-word byte-strobed stores and line-refill bursts from the L1 controller.
- Returns data after a fixed programmable access latency, with refill bursts returned critical-word-first.
- Backed by an internal word-addressed storage array. Used as the memory model in L1D simulation and as the memory-side controller skeleton.

Parameters:
- DEPTH_WORDS, 65536, storage depth in 32-bit words (power of two).
- LINE_WORDS, 8, words per cache line and burst length (power of two, ≥2).
- LATENCY, 4, cycles from request acceptance to the first response beat or write commit (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- l1_mem_valid  in  1  request valid
- l1_mem_store  in  1  0 = load, 1 = store
- l1_mem_burst  in  1  1 = line refill burst (loads only)
- l1_mem_addr  in  32  byte address
- l1_mem_wdata  in  32  store data
- l1_mem_wstrb  in  4  store byte enables
- mem_l1_ready  out  1  responder can accept a request
- mem_l1_valid  out  1  response beat / store ack valid
- mem_l1_rdata  out  32  read data for the beat
- mem_l1_last  out  1  final beat of the response

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - During reset, mem_l1_ready=0, mem_l1_valid=0, mem_l1_rdata=0, mem_l1_last=0, state=IDLE, counters cleared.
  - Storage contents are not reset.
- Word index = l1_mem_addr[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored (aliasing). Bits [1:0] are ignored.
- Handshake:
  - Request accepted on the rising edge where l1_mem_valid && mem_l1_ready.
  - addr/wdata/wstrb/store/burst are captured at acceptance; inputs are don't-care afterwards.
  - mem_l1_ready=1 only in IDLE (and not in reset). One outstanding request.
  - No response backpressure: L1 must sink every beat.
- FSM states:
  - IDLE: ready=1. On acceptance, go to WAIT with lat_cnt=LATENCY-1.
  - WAIT: decrement lat_cnt each cycle. When lat_cnt==0, go to BEAT for loads or COMMIT for stores. If LATENCY==1, WAIT lasts exactly one cycle.
  - BEAT: valid=1, rdata=mem[beat_addr].
    - Single load (burst=0): one beat, last=1, go to IDLE.
    - Burst: LINE_WORDS consecutive beats, one per cycle. Beat order starts at the requested word and wraps within the aligned line: word_in_line = (start + k) mod LINE_WORDS, line base bits held constant. last=1 on beat LINE_WORDS-1, then go to IDLE.
  - COMMIT: byte-merge wdata into mem[idx] per wstrb, same cycle. valid=1, last=1, rdata=0 (one-cycle ack). Go to IDLE. wstrb=0 commits nothing but still acks.
- Timing: acceptance at edge E0 → first beat/ack visible in the cycle after edge E0+LATENCY. ready re-asserts the cycle after last. Total occupancy = LATENCY + beats + 0 dead cycles.
- store=1 with burst=1: burst ignored, treated as single store.
- Read-after-write: a load accepted after a store ack returns the merged data.
- Outside BEAT/COMMIT, valid=0, last=0, and rdata holds 0.
- Reset mid-operation:
  - Aborts immediately; outputs go to reset values.
  - A store not yet in COMMIT is dropped. Remaining burst beats are discarded.
  - ready=1 the first cycle after rst_n deasserts.
- Request asserted while not ready: ignored, not queued. L1 holds valid until accepted.

Test Plan:
- Store addr 0x0000_0040, wdata 0xDEADBEEF, wstrb 0xF, LATENCY=4 → ack (valid=1, last=1) 4 cycles after acceptance. Then single load 0x40 → rdata 0xDEADBEEF, last=1.
- Byte merge: store 0x11223344 wstrb 0xF to 0x80, then 0xAABBCCDD wstrb 0x5 → load returns 0x11BB33DD.
- Burst at 0x0000_0014 (word 5) after writing word i of the line at 0x00 as value i → beats return 5,6,7,0,1,2,3,4 on consecutive cycles, last only on the 8th, ready back the next cycle.
- Back-to-back: valid held high across two loads → second accepted only when ready=1. No beat overlap. mem_l1_ready low throughout WAIT/BEAT.
- Reset asserted during WAIT of a store to 0x100 (prior value 0x0) → outputs 0 immediately. After release, load 0x100 returns 0x0 and ready=1 the first cycle.
- Alias/edge cases: LATENCY=1 store/load to addr 0x0004_0000 (aliases word 0) → ack/beat one cycle after acceptance. Load of 0x0 returns the stored value. store+burst=1 acks with a single beat.
